// File: rtl/lru_set_tracker.sv
// Per-set true-LRU age store with two hit ports, an init walk and a
// lock-aware victim read port that answers one cycle later.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   flush        restart the init walk (only when not busy)
//   busy         init walk in progress; hits and reads are dropped
//   hitA_*       hit port A: enable, set, way (A is the most recent)
//   hitB_*       hit port B: enable, set, way
//   rd_en/rd_set victim lookup request
//   lock_mask    ways that must not be chosen as the victim
//   victim_vld   one-cycle pulse when a victim was found
//   victim_way   chosen victim; holds its value when nothing is found
module lru_set_tracker #(
  parameter int WAYS = 8,
  parameter int SETS = 16,
  localparam int WAY_W = $clog2(WAYS),
  localparam int SET_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  output logic             busy,
  input  logic             hitA_en,
  input  logic [SET_W-1:0] hitA_set,
  input  logic [WAY_W-1:0] hitA_way,
  input  logic             hitB_en,
  input  logic [SET_W-1:0] hitB_set,
  input  logic [WAY_W-1:0] hitB_way,
  input  logic             rd_en,
  input  logic [SET_W-1:0] rd_set,
  input  logic [WAYS-1:0]  lock_mask,
  output logic             victim_vld,
  output logic [WAY_W-1:0] victim_way
);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  typedef logic [WAYS-1:0][WAY_W-1:0] row_t;

  row_t [SETS-1:0]  age_q, age_d;
  logic [0:0]       state_q, state_d;
  logic [SET_W-1:0] idx_q, idx_d;
  logic             vld_q;
  logic [WAY_W-1:0] way_q;

  // Make way h the MRU; everything younger than it ages by one.
  function automatic row_t touch(row_t r, logic [WAY_W-1:0] h);
    row_t o;
    logic [WAY_W-1:0] a;
    a = r[h];
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == h) o[w] = '0;
      else if (r[w] < a) o[w] = r[w] + WAY_W'(1);
      else o[w] = r[w];
    end
    return o;
  endfunction

  assign busy = (state_q == ST_INIT);

  always_comb begin
    row_t ident;
    row_t tmp;
    age_d   = age_q;
    state_d = state_q;
    idx_d   = idx_q;
    ident   = '0;
    tmp     = '0;
    for (int w = 0; w < WAYS; w++) ident[w] = WAY_W'(w);
    case (state_q)
      ST_INIT: begin
        age_d[idx_q] = ident;
        idx_d = idx_q + SET_W'(1);
        if (idx_q == SET_W'(SETS - 1)) state_d = ST_READY;
      end
      default: begin
        // B then A gives the dual-hit ordering, and a
        // same-way pair collapses into a single A hit.
        for (int s = 0; s < SETS; s++) begin
          tmp = age_q[s];
          if (hitB_en && hitB_set == SET_W'(s))
            tmp = touch(tmp, hitB_way);
          if (hitA_en && hitA_set == SET_W'(s))
            tmp = touch(tmp, hitA_way);
          age_d[s] = tmp;
        end
        if (flush) begin
          state_d = ST_INIT;
          idx_d   = '0;
        end
      end
    endcase
  end

  logic             found;
  logic [WAY_W-1:0] best;
  logic [WAY_W-1:0] best_age;
  row_t             rrow;

  always_comb begin
    rrow     = age_q[rd_set];
    found    = 1'b0;
    best     = '0;
    best_age = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!lock_mask[w] && (!found || rrow[w] > best_age)) begin
        found    = 1'b1;
        best     = WAY_W'(w);
        best_age = rrow[w];
      end
    end
  end

  // Age storage is not reset; the walk initialises it.
  always_ff @(posedge clk) begin
    if (!rst) age_q <= age_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      way_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vld_q   <= rd_en && !busy && found;
      if (rd_en && !busy && found) way_q <= best;
    end
  end

  assign victim_vld = vld_q;
  assign victim_way = way_q;

endmodule

// File: tb/tb_lru_set_tracker.sv
// Directed plus short random bench for lru_set_tracker with a
// behavioural age model and a victim scoreboard.
module tb_lru_set_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       busy;
  logic       hitA_en = 1'b0;
  logic [3:0] hitA_set = '0;
  logic [2:0] hitA_way = '0;
  logic       hitB_en = 1'b0;
  logic [3:0] hitB_set = '0;
  logic [2:0] hitB_way = '0;
  logic       rd_en = 1'b0;
  logic [3:0] rd_set = '0;
  logic [7:0] lock_mask = '0;
  logic       victim_vld;
  logic [2:0] victim_way;

  lru_set_tracker #(.WAYS(8), .SETS(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .busy(busy),
    .hitA_en(hitA_en), .hitA_set(hitA_set), .hitA_way(hitA_way),
    .hitB_en(hitB_en), .hitB_set(hitB_set), .hitB_way(hitB_way),
    .rd_en(rd_en), .rd_set(rd_set), .lock_mask(lock_mask),
    .victim_vld(victim_vld), .victim_way(victim_way)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       vld;
    logic [2:0] way;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int   m_age[16][8];
  bit   m_valid[16];
  bit   m_init = 1'b1;
  int   m_idx = 0;
  int   m_last = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(int a0, int a1, int a2, int a3,
                                     int a4, int a5, int a6, int a7);
    return {8'h0, 3'(a7), 3'(a6), 3'(a5), 3'(a4),
            3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  function automatic logic [31:0] drow(int s);
    logic [31:0] r;
    r = '0;
    for (int w = 0; w < 8; w++) r[w*3 +: 3] = dut.age_q[s][w];
    return r;
  endfunction

  task automatic m_single(int s, int h);
    int a;
    a = m_age[s][h];
    for (int w = 0; w < 8; w++)
      if (w == h) m_age[s][w] = 0;
      else if (m_age[s][w] < a) m_age[s][w]++;
  endtask

  task automatic m_dual(int s, int wa, int wb);
    int lo, hi, g;
    lo = m_age[s][wa];
    hi = m_age[s][wb];
    if (lo > hi) begin g = lo; lo = hi; hi = g; end
    for (int w = 0; w < 8; w++) begin
      g = m_age[s][w];
      if (w == wa) m_age[s][w] = 0;
      else if (w == wb) m_age[s][w] = 1;
      else if (g > hi) m_age[s][w] = g;
      else if (g > lo) m_age[s][w] = g + 1;
      else m_age[s][w] = g + 2;
    end
  endtask

  task automatic m_victim(int s, logic [7:0] lk,
                          output bit f, output int v);
    f = 0;
    v = 0;
    for (int a = 7; a >= 0; a--)
      for (int w = 0; w < 8; w++)
        if (!f && m_age[s][w] == a && !lk[w]) begin
          f = 1;
          v = w;
        end
  endtask

  task automatic step();
    exp_t e;
    bit   f;
    int   v;
    logic [7:0] seen;
    if (rst) begin
      m_last = 0;
      e = '{vld: 1'b0, way: 3'd0};
    end else if (rd_en && !m_init) begin
      m_victim(int'(rd_set), lock_mask, f, v);
      if (f) m_last = v;
      e = '{vld: f, way: 3'(m_last)};
    end else begin
      e = '{vld: 1'b0, way: 3'(m_last)};
    end
    q.push_back(e);
    if (rst) begin
      m_init = 1;
      m_idx = 0;
    end else if (m_init) begin
      for (int w = 0; w < 8; w++) m_age[m_idx][w] = w;
      m_valid[m_idx] = 1;
      m_idx++;
      if (m_idx == 16) m_init = 0;
    end else begin
      if (hitA_en && hitB_en && hitA_set == hitB_set
          && hitA_way != hitB_way)
        m_dual(int'(hitA_set), int'(hitA_way), int'(hitB_way));
      else begin
        if (hitB_en && !(hitA_en && hitA_set == hitB_set))
          m_single(int'(hitB_set), int'(hitB_way));
        if (hitA_en) m_single(int'(hitA_set), int'(hitA_way));
      end
      if (flush) begin
        m_init = 1;
        m_idx = 0;
      end
    end
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("victim_vld", 32'(victim_vld), 32'(e.vld));
    chk("victim_way", 32'(victim_way), 32'(e.way));
    chk("busy", 32'(busy), 32'(m_init));
    for (int s = 0; s < 16; s++) begin
      if (m_valid[s]) begin
        seen = '0;
        for (int w = 0; w < 8; w++) seen[dut.age_q[s][w]] = 1'b1;
        chk($sformatf("perm_set%0d", s), 32'(seen), 32'hFF);
        chk($sformatf("ages_set%0d", s), drow(s),
            mk(m_age[s][0], m_age[s][1], m_age[s][2], m_age[s][3],
               m_age[s][4], m_age[s][5], m_age[s][6], m_age[s][7]));
      end
    end
  endtask

  task automatic idle();
    hitA_en = 0; hitB_en = 0; rd_en = 0; flush = 0; lock_mask = '0;
  endtask

  task automatic rand_in();
    hitA_en  = 1'($urandom_range(0, 1));
    hitA_set = 4'($urandom_range(0, 3));
    hitA_way = 3'($urandom_range(0, 7));
    hitB_en  = 1'($urandom_range(0, 1));
    hitB_set = 4'($urandom_range(0, 3));
    hitB_way = 3'($urandom_range(0, 7));
    rd_en    = 1'($urandom_range(0, 1));
    rd_set   = 4'($urandom_range(0, 3));
    lock_mask = ($urandom_range(0, 3) == 0) ? 8'hFF
                                            : 8'($urandom_range(0, 255));
  endtask

  initial begin
    for (int s = 0; s < 16; s++) m_valid[s] = 0;
    rst = 1;
    step();
    rst = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("busy_during_walk", 32'(busy), 32'd1);
    end
    step();
    chk("busy_after_walk", 32'(busy), 32'd0);

    rd_en = 1; rd_set = 5;
    step();
    idle();
    chk("t1_victim", 32'(victim_way), 32'd7);

    hitA_en = 1; hitA_set = 3; hitA_way = 7;
    step();
    idle();
    chk("t2_ages", drow(3), mk(1, 2, 3, 4, 5, 6, 7, 0));
    rd_en = 1; rd_set = 3;
    step();
    idle();
    chk("t2_victim", 32'(victim_way), 32'd6);

    hitA_en = 1; hitA_set = 0; hitA_way = 2;
    hitB_en = 1; hitB_set = 0; hitB_way = 5;
    step();
    idle();
    chk("t3_ages", drow(0), mk(2, 3, 0, 4, 5, 1, 6, 7));
    rd_en = 1; rd_set = 0;
    step();
    idle();
    chk("t3_victim", 32'(victim_way), 32'd7);

    rd_en = 1; rd_set = 1; lock_mask = 8'h80;
    step();
    chk("t4_vld", 32'(victim_vld), 32'd1);
    chk("t4_victim", 32'(victim_way), 32'd6);
    lock_mask = 8'hFF;
    step();
    idle();
    chk("t4_all_locked_vld", 32'(victim_vld), 32'd0);
    chk("t4_all_locked_hold", 32'(victim_way), 32'd6);

    hitA_en = 1; hitA_set = 2; hitA_way = 7;
    rd_en = 1; rd_set = 2;
    step();
    hitA_en = 0;
    chk("t5_old_state", 32'(victim_way), 32'd7);
    step();
    idle();
    chk("t5_new_state", 32'(victim_way), 32'd6);
    step();
    chk("t5_vld_drop", 32'(victim_vld), 32'd0);

    hitA_en = 1; hitA_set = 6; hitA_way = 4;
    hitB_en = 1; hitB_set = 6; hitB_way = 4;
    step();
    chk("same_way", drow(6), mk(1, 2, 3, 4, 0, 5, 6, 7));
    hitA_set = 7; hitA_way = 1; hitB_set = 8; hitB_way = 6;
    step();
    idle();
    chk("diff_set_a", drow(7), mk(1, 0, 2, 3, 4, 5, 6, 7));
    chk("diff_set_b", drow(8), mk(1, 2, 3, 4, 5, 6, 0, 7));

    for (int i = 0; i < 60; i++) begin
      rand_in();
      step();
    end
    idle();

    flush = 1; hitA_en = 1; hitA_set = 4; hitA_way = 3;
    step();
    idle();
    chk("flush_hit_applied", drow(4), mk(1, 2, 3, 0, 4, 5, 6, 7));
    for (int i = 0; i < 16; i++) begin
      rand_in();
      flush = 1'($urandom_range(0, 1));
      step();
    end
    idle();
    chk("flush_walk_done", 32'(busy), 32'd0);

    flush = 1;
    step();
    flush = 0;
    for (int i = 0; i < 9; i++) begin
      rand_in();
      step();
    end
    idle();
    rst = 1;
    step();
    rst = 0;
    for (int i = 0; i < 15; i++) step();
    chk("rst_walk_busy", 32'(busy), 32'd1);
    step();
    chk("rst_walk_done", 32'(busy), 32'd0);
    for (int i = 0; i < 20; i++) begin
      rand_in();
      step();
    end
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
